rtc_cmos: RTL and testbench

RTC_CMOS -- requirements
Module: rtc_cmos

---
 rtl/rtc_cmos_pkg.sv | 54 +++++
 rtl/rtc_cmos_bcd_counter.sv | 50 +++++
 rtl/rtc_cmos.sv | 156 +++++++++++++++
 tb/tb_rtc_cmos.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_cmos_pkg.sv
// rtc_cmos_pkg -- shared constants for the CMOS real-time clock.
// Holds the I/O port numbers, the CMOS register indices, the reset
// date/time values and a month-length helper used by the date counter.
package rtc_cmos_pkg;

    localparam logic [15:0] PORT_INDEX = 16'h0070;
    localparam logic [15:0] PORT_DATA  = 16'h0071;

    localparam logic [5:0] IDX_SEC      = 6'h00;
    localparam logic [5:0] IDX_ALM_SEC  = 6'h01;
    localparam logic [5:0] IDX_MIN      = 6'h02;
    localparam logic [5:0] IDX_ALM_MIN  = 6'h03;
    localparam logic [5:0] IDX_HOUR     = 6'h04;
    localparam logic [5:0] IDX_ALM_HOUR = 6'h05;
    localparam logic [5:0] IDX_DOW      = 6'h06;
    localparam logic [5:0] IDX_DATE     = 6'h07;
    localparam logic [5:0] IDX_MONTH    = 6'h08;
    localparam logic [5:0] IDX_YEAR     = 6'h09;
    localparam logic [5:0] IDX_REGA     = 6'h0A;
    localparam logic [5:0] IDX_REGB     = 6'h0B;
    localparam logic [5:0] IDX_REGC     = 6'h0C;
    localparam logic [5:0] IDX_REGD     = 6'h0D;
    localparam logic [5:0] IDX_RAM_LO   = 6'h0E;

    localparam int RAM_BYTES = 50;

    localparam logic [7:0] RST_SEC   = 8'h00;
    localparam logic [7:0] RST_MIN   = 8'h00;
    localparam logic [7:0] RST_HOUR  = 8'h00;
    localparam logic [7:0] RST_DOW   = 8'h01;
    localparam logic [7:0] RST_DATE  = 8'h01;
    localparam logic [7:0] RST_MONTH = 8'h01;
    localparam logic [7:0] RST_YEAR  = 8'h00;
    localparam logic [7:0] RST_REGB  = 8'h02;

    localparam logic [6:0] REGA_LOW = 7'h26;
    localparam logic [7:0] REGD_VAL = 8'h80;

    // Last valid date (BCD) of a month. A BCD year is a multiple of 4
    // when the tens digit is even and units in {0,4,8}, or tens odd and
    // units in {2,6}.
    function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                                 input logic [7:0] year);
        logic leap;
        leap = year[4] ? (year[3:0] == 4'h2 || year[3:0] == 4'h6)
                       : (year[3:0] == 4'h0 || year[3:0] == 4'h4 || year[3:0] == 4'h8);
        case (month)
            8'h02:                      days_in_month = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: days_in_month = 8'h30;
            default:                    days_in_month = 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/rtc_cmos_bcd_counter.sv
// rtc_bcd_counter -- one BCD time field with programmable range.
//   clk_i/rst_i : clock, async active-high reset (loads RST_VAL)
//   inc_i       : advance by one (carry in from the lower field)
//   wr_i/wdata_i: CPU load; a load beats a simultaneous increment
//   min_i/max_i : wrap range (BCD); reaching max wraps to min
//   q_o         : current value, carry_o: inc_i while at/above max
module rtc_bcd_counter #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       wr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] min_i,
    input  logic [7:0] max_i,
    output logic [7:0] q_o,
    output logic       carry_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       at_max;

    // BCD compares like binary, so >= also recovers out-of-range values
    // written by software.
    assign at_max  = cnt_q >= max_i;
    // Carry is taken from the old value so a CPU load still propagates it.
    assign carry_o = inc_i & at_max;
    assign q_o     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_i)
            cnt_d = wdata_i;
        else if (inc_i) begin
            if (at_max)
                cnt_d = min_i;
            else if (cnt_q[3:0] >= 4'h9)
                cnt_d = {cnt_q[7:4] + 4'h1, 4'h0};
            else
                cnt_d = {cnt_q[7:4], cnt_q[3:0] + 4'h1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= RST_VAL;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rtc_cmos.sv
// rtc_cmos -- PC-style CMOS RTC behind index/data I/O ports 0x70/0x71.
//   iClk, iRst    : bus clock, async active-high reset
//   iAddr/iWr/iRd : CPU I/O cycle (bits [15:0] decode the port)
//   iData/oData   : write data / read data (valid in the iRd cycle)
//   oSel          : data-port read decode
//   oIrq          : interrupt, follows regC.IRQF
// Optional: define RTC_PERIODIC_INT_EN for the 1024 Hz periodic flag.
`ifndef CLOCK_SPEED
`define CLOCK_SPEED 50000000
`endif
module rtc_cmos
    import rtc_cmos_pkg::*;
#(
    parameter int CLK_IN = `CLOCK_SPEED
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [19:0] iAddr,
    input  logic        iWr,
    input  logic        iRd,
    input  logic [7:0]  iData,
    output logic [7:0]  oData,
    output logic        oSel,
    output logic        oIrq
);

    localparam int UIP_CNT = CLK_IN / 4096;

    logic        idx_wr, dat_wr, rdc;
    logic [5:0]  index_q, ram_addr;
    logic [31:0] div_q;
    logic        tick, uip, run;
    logic [7:0]  regb_q, rd_val;
    logic        pf_q, irqf_q, pf_set;
    logic [7:0]  alarm_q [3];
    logic [7:0]  ram_q [RAM_BYTES];
    logic        addr_hi_unused;

    logic [7:0] sec_q, min_q, hour_q, dow_q, date_q, month_q, year_q;
    logic       c_sec, c_min, c_hour, c_dow, c_date, c_month, c_year;
    logic       c_dow_unused, c_year_unused;

    assign addr_hi_unused = ^iAddr[19:16];
    assign c_dow_unused   = c_dow;
    assign c_year_unused  = c_year;

    assign oSel   = iRd && (iAddr[15:0] == PORT_DATA);
    assign idx_wr = iWr && (iAddr[15:0] == PORT_INDEX);
    assign dat_wr = iWr && (iAddr[15:0] == PORT_DATA);
    assign rdc    = oSel && (index_q == IDX_REGC);

    assign ram_addr = index_q - IDX_RAM_LO;

    assign tick = div_q == 32'(CLK_IN - 1);
    assign run  = tick && !regb_q[7];
    // With UIP_CNT = 0 the threshold equals CLK_IN and UIP never asserts.
    assign uip  = !regb_q[7] && (div_q >= 32'(CLK_IN - UIP_CNT));

    // Time fields, chained lowest to highest through their carries.
    rtc_bcd_counter #(.RST_VAL(RST_SEC)) u_sec (
        .clk_i(iClk), .rst_i(iRst), .inc_i(run),
        .wr_i(dat_wr && index_q == IDX_SEC), .wdata_i(iData),
        .min_i(8'h00), .max_i(8'h59), .q_o(sec_q), .carry_o(c_sec));
    rtc_bcd_counter #(.RST_VAL(RST_MIN)) u_min (
        .clk_i(iClk), .rst_i(iRst), .inc_i(c_sec),
        .wr_i(dat_wr && index_q == IDX_MIN), .wdata_i(iData),
        .min_i(8'h00), .max_i(8'h59), .q_o(min_q), .carry_o(c_min));
    rtc_bcd_counter #(.RST_VAL(RST_HOUR)) u_hour (
        .clk_i(iClk), .rst_i(iRst), .inc_i(c_min),
        .wr_i(dat_wr && index_q == IDX_HOUR), .wdata_i(iData),
        .min_i(8'h00), .max_i(8'h23), .q_o(hour_q), .carry_o(c_hour));
    rtc_bcd_counter #(.RST_VAL(RST_DOW)) u_dow (
        .clk_i(iClk), .rst_i(iRst), .inc_i(c_hour),
        .wr_i(dat_wr && index_q == IDX_DOW), .wdata_i(iData),
        .min_i(8'h01), .max_i(8'h07), .q_o(dow_q), .carry_o(c_dow));
    rtc_bcd_counter #(.RST_VAL(RST_DATE)) u_date (
        .clk_i(iClk), .rst_i(iRst), .inc_i(c_hour),
        .wr_i(dat_wr && index_q == IDX_DATE), .wdata_i(iData),
        .min_i(8'h01), .max_i(days_in_month(month_q, year_q)),
        .q_o(date_q), .carry_o(c_date));
    rtc_bcd_counter #(.RST_VAL(RST_MONTH)) u_month (
        .clk_i(iClk), .rst_i(iRst), .inc_i(c_date),
        .wr_i(dat_wr && index_q == IDX_MONTH), .wdata_i(iData),
        .min_i(8'h01), .max_i(8'h12), .q_o(month_q), .carry_o(c_month));
    rtc_bcd_counter #(.RST_VAL(RST_YEAR)) u_year (
        .clk_i(iClk), .rst_i(iRst), .inc_i(c_month),
        .wr_i(dat_wr && index_q == IDX_YEAR), .wdata_i(iData),
        .min_i(8'h00), .max_i(8'h99), .q_o(year_q), .carry_o(c_year));

`ifdef RTC_PERIODIC_INT_EN
    localparam int PER_CNT = (CLK_IN / 1024 > 0) ? CLK_IN / 1024 : 1;
    logic [31:0] pdiv_q;

    assign pf_set = pdiv_q == 32'(PER_CNT - 1);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)        pdiv_q <= '0;
        else if (pf_set) pdiv_q <= '0;
        else             pdiv_q <= pdiv_q + 32'd1;
    end
`else
    assign pf_set = 1'b0;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            index_q <= '0;
            div_q   <= '0;
            regb_q  <= RST_REGB;
            pf_q    <= 1'b0;
            irqf_q  <= 1'b0;
            for (int i = 0; i < 3; i++)         alarm_q[i] <= '0;
            for (int i = 0; i < RAM_BYTES; i++) ram_q[i]   <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 32'd1;
            if (idx_wr)
                index_q <= iData[5:0];
            if (dat_wr) begin
                if (index_q == IDX_REGB)
                    regb_q <= iData | 8'h02;   // 24 h mode bit is fixed
                else if (index_q == IDX_ALM_SEC || index_q == IDX_ALM_MIN ||
                         index_q == IDX_ALM_HOUR)
                    alarm_q[index_q[2:1]] <= iData;
                else if (index_q >= IDX_RAM_LO)
                    ram_q[ram_addr] <= iData;
            end
            // A set event in the same cycle as a regC read keeps the flag.
            pf_q   <= pf_set | (pf_q & ~rdc);
            irqf_q <= (pf_set & regb_q[6]) | (irqf_q & ~rdc);
        end
    end

    always_comb begin
        rd_val = 8'h00;
        case (index_q)
            IDX_SEC:   rd_val = sec_q;
            IDX_MIN:   rd_val = min_q;
            IDX_HOUR:  rd_val = hour_q;
            IDX_DOW:   rd_val = dow_q;
            IDX_DATE:  rd_val = date_q;
            IDX_MONTH: rd_val = month_q;
            IDX_YEAR:  rd_val = year_q;
            IDX_ALM_SEC, IDX_ALM_MIN, IDX_ALM_HOUR:
                       rd_val = alarm_q[index_q[2:1]];
            IDX_REGA:  rd_val = {uip, REGA_LOW};
            IDX_REGB:  rd_val = regb_q;
            IDX_REGC:  rd_val = {irqf_q, pf_q, 6'b0};
            IDX_REGD:  rd_val = REGD_VAL;
            default:   rd_val = ram_q[ram_addr];
        endcase
    end

    assign oData = (oSel && !iRst) ? rd_val : 8'h00;
    assign oIrq  = irqf_q;

endmodule

// File: tb/tb_rtc_cmos.sv
module tb_rtc_cmos;

    localparam int CLK = 4096;
`ifdef RTC_PERIODIC_INT_EN
    localparam logic [7:0] REGC_IDLE = 8'h40;   // PF sets every 4 cycles, PIE = 0
`else
    localparam logic [7:0] REGC_IDLE = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] addr;
    logic        wr, rd;
    logic [7:0]  wdat, rdat;
    logic        sel, irq;

    rtc_cmos #(.CLK_IN(CLK)) dut (
        .iClk(clk), .iRst(rst), .iAddr(addr), .iWr(wr), .iRd(rd),
        .iData(wdat), .oData(rdat), .oSel(sel), .oIrq(irq));

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ph;

    // Seconds-divider phase: value the divider holds after each edge.
    always @(posedge clk or posedge rst)
        if (rst) ph <= 0;
        else     ph <= (ph == CLK - 1) ? 0 : ph + 1;

    // Monitor: every data-port read is matched against the scoreboard.
    always @(negedge clk) begin
        if (sel && !rst) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_read: got %02h, nothing expected", rdat);
            end else begin
                mon_e = sb.pop_front();
                if (rdat !== mon_e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %02h expected %02h", mon_e.name, rdat, mon_e.exp);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", nm, got, exp);
        end
    endtask

    // All accesses start and end at posedge+1.
    task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
        addr = {4'h0, a}; wdat = d; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic io_rd(input string nm, input logic [7:0] e, input logic [19:0] a);
        exp_t t;
        t.name = nm; t.exp = e;
        sb.push_back(t);
        addr = a; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] idx, input logic [7:0] d);
        io_wr(16'h0070, idx);
        io_wr(16'h0071, d);
    endtask

    task automatic rd_reg(input string nm, input logic [7:0] idx, input logic [7:0] e);
        io_wr(16'h0070, idx);
        io_rd(nm, e, 20'h00071);
    endtask

    task automatic sync(input int p);
        int n;
        n = 0;
        while (ph != p && n < 2 * CLK) begin
            @(posedge clk); #1;
            n++;
        end
        if (ph != p) check("sync_timeout", 8'(ph), 8'(p));
    endtask

    // Run up to and through the next seconds tick; optionally read regA
    // in the tick cycle itself, where UIP is asserted.
    task automatic tick_chk(input bit chk, input string nm, input logic [7:0] expa);
        if (chk) io_wr(16'h0070, 8'h0A);
        sync(CLK - 1);
        if (chk) io_rd(nm, expa, 20'h00071);
        else begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_state(input string tag);
        io_rd({tag, "_index0_sec"}, 8'h00, 20'h00071);
        rd_reg({tag, "_min"},   8'h02, 8'h00);
        rd_reg({tag, "_hour"},  8'h04, 8'h00);
        rd_reg({tag, "_dow"},   8'h06, 8'h01);
        rd_reg({tag, "_date"},  8'h07, 8'h01);
        rd_reg({tag, "_month"}, 8'h08, 8'h01);
        rd_reg({tag, "_year"},  8'h09, 8'h00);
        rd_reg({tag, "_alm1"},  8'h01, 8'h00);
        rd_reg({tag, "_rega"},  8'h0A, 8'h26);
        rd_reg({tag, "_regb"},  8'h0B, 8'h02);
        rd_reg({tag, "_regc"},  8'h0C, REGC_IDLE);
        rd_reg({tag, "_regd"},  8'h0D, 8'h80);
        rd_reg({tag, "_ram0e"}, 8'h0E, 8'h00);
        rd_reg({tag, "_ram3f"}, 8'h3F, 8'h00);
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wdat = '0;
        repeat (3) @(posedge clk);
        #1;
        rd = 1'b1; addr = 20'h00071;
        #1;
        check("rst_odata", rdat, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        check_reset_state("por");
        rd = 1'b1; addr = 20'h00070;
        #1;
        check("sel_index_port", {7'b0, sel}, 8'h00);
        rd = 1'b0;
        @(posedge clk); #1;

        // 23:59:59 rolls to midnight: date and dow advance
        wr_reg(8'h00, 8'h59); wr_reg(8'h02, 8'h59); wr_reg(8'h04, 8'h23);
        tick_chk(1'b1, "uip_at_tick", 8'hA6);
        rd_reg("mid_sec",  8'h00, 8'h00);
        rd_reg("mid_min",  8'h02, 8'h00);
        rd_reg("mid_hour", 8'h04, 8'h00);
        rd_reg("mid_date", 8'h07, 8'h02);
        rd_reg("mid_dow",  8'h06, 8'h02);
        rd_reg("mid_month", 8'h08, 8'h01);

        // Leap year 24: Feb 28 -> 29; dow 7 -> 1
        wr_reg(8'h09, 8'h24); wr_reg(8'h08, 8'h02); wr_reg(8'h07, 8'h28);
        wr_reg(8'h06, 8'h07);
        wr_reg(8'h04, 8'h23); wr_reg(8'h02, 8'h59); wr_reg(8'h00, 8'h59);
        tick_chk(1'b0, "", 8'h00);
        rd_reg("leap_date",  8'h07, 8'h29);
        rd_reg("leap_month", 8'h08, 8'h02);
        rd_reg("dow_wrap",   8'h06, 8'h01);

        // Year 23: Feb 28 -> Mar 1
        wr_reg(8'h09, 8'h23); wr_reg(8'h07, 8'h28);
        wr_reg(8'h04, 8'h23); wr_reg(8'h02, 8'h59); wr_reg(8'h00, 8'h59);
        tick_chk(1'b0, "", 8'h00);
        rd_reg("nonleap_date",  8'h07, 8'h01);
        rd_reg("nonleap_month", 8'h08, 8'h03);
        rd_reg("nonleap_year",  8'h09, 8'h23);

        // Apr 30 -> May 1
        wr_reg(8'h08, 8'h04); wr_reg(8'h07, 8'h30);
        wr_reg(8'h04, 8'h23); wr_reg(8'h02, 8'h59); wr_reg(8'h00, 8'h59);
        tick_chk(1'b0, "", 8'h00);
        rd_reg("apr30_date",  8'h07, 8'h01);
        rd_reg("apr30_month", 8'h08, 8'h05);

        // Dec 31 99 -> Jan 1 00
        wr_reg(8'h09, 8'h99); wr_reg(8'h08, 8'h12); wr_reg(8'h07, 8'h31);
        wr_reg(8'h04, 8'h23); wr_reg(8'h02, 8'h59); wr_reg(8'h00, 8'h59);
        tick_chk(1'b0, "", 8'h00);
        rd_reg("ny_date",  8'h07, 8'h01);
        rd_reg("ny_month", 8'h08, 8'h01);
        rd_reg("ny_year",  8'h09, 8'h00);

        // SET freezes time and suppresses UIP
        wr_reg(8'h0B, 8'h80);
        wr_reg(8'h00, 8'h10);
        tick_chk(1'b1, "set_uip1", 8'h26);
        tick_chk(1'b1, "set_uip2", 8'h26);
        tick_chk(1'b1, "set_uip3", 8'h26);
        rd_reg("set_sec",  8'h00, 8'h10);
        rd_reg("set_regb", 8'h0B, 8'h82);
        wr_reg(8'h0B, 8'h00);
        tick_chk(1'b1, "run_uip", 8'hA6);
        rd_reg("run_sec", 8'h00, 8'h11);

        // CPU write of sec in the tick cycle wins; carry still reaches min
        wr_reg(8'h00, 8'h59); wr_reg(8'h02, 8'h05);
        io_wr(16'h0070, 8'h00);
        sync(CLK - 1);
        io_wr(16'h0071, 8'h30);
        rd_reg("race_sec", 8'h00, 8'h30);
        rd_reg("race_min", 8'h02, 8'h06);

        // RAM, alarm storage, read-only registers
        wr_reg(8'h0E, 8'hA5); wr_reg(8'h3F, 8'h5A); wr_reg(8'h03, 8'h11);
        wr_reg(8'h0A, 8'hFF); wr_reg(8'h0D, 8'h00);
        rd_reg("ram0e", 8'h0E, 8'hA5);
        rd_reg("ram3f", 8'h3F, 8'h5A);
        rd_reg("alm3",  8'h03, 8'h11);
        rd_reg("rega_ro", 8'h0A, 8'h26);
        rd_reg("regd_ro", 8'h0D, 8'h80);
        rd_reg("index_hi_ignored", 8'hCE, 8'hA5);
        io_rd("addr_hi_ignored", 8'hA5, 20'hA0071);

        // Periodic interrupt
        wr_reg(8'h0B, 8'h40);
`ifdef RTC_PERIODIC_INT_EN
        begin
            int n;
            n = 0;
            while (!irq && n <= CLK / 1024) begin @(posedge clk); #1; n++; end
            check("irq_rise", {7'b0, irq}, 8'h01);
            io_wr(16'h0070, 8'h0C);
            io_rd("regc_flags", 8'hC0, 20'h00071);
            check("irq_fall", {7'b0, irq}, 8'h00);
            wr_reg(8'h0B, 8'h00);
        end
`else
        repeat (8) @(posedge clk);
        #1;
        check("irq_off", {7'b0, irq}, 8'h00);
        rd_reg("regc_off", 8'h0C, 8'h00);
`endif

        // Reset in the middle of a data-port write
        io_wr(16'h0070, 8'h0E);
        addr = 20'h00071; wdat = 8'h77; wr = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        wr = 1'b0; rd = 1'b1;
        #1;
        check("rst2_odata", rdat, 8'h00);
        check("rst2_irq", {7'b0, irq}, 8'h00);
        rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state("rst2");

        repeat (2) @(posedge clk);
        if (sb.size() != 0) check("scoreboard_drain", 8'(sb.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
